instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_instr_fetch.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------------------------
// instr_fetch -- single-outstanding instruction fetch unit
//
// Issues one request at a time to instruction memory, holds the returned word (and the address
// it came from) until the decode stage consumes it, then advances by one word. A redirect
// (branch/jump taken) replaces the next fetch address from any state. Any response still in
// flight when the redirect arrives is thrown away.
//
// Optional feature, selected by the macro IFETCH_ALIGN_CHK_EN:
//   defined   - a fetch address with non-zero low bits is never issued. The unit parks in a
//               fault state with fetch_fault=1 until the next redirect.
//   undefined - there is no fault state, fetch_fault is tied low, and the low two address
//               bits are forced to zero.
//
// Parameters
//   RESET_PC     address of the first fetch after reset
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address, valid while imem_req=1
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  read data valid
//   imem_rdata   read data word
//   instr        held instruction word for decode
//   pc           address the held instruction was fetched from
//   instr_valid  instr/pc hold a valid instruction
//   instr_ready  downstream consumes instr this cycle
//   pc_wr_en     redirect request
//   pc_next      redirect target
//   fetch_fault  misaligned fetch target detected
// ---------------------------------------------------------------------------------------------

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_wr_en,
  input  logic [31:0] pc_next,
  output logic        fetch_fault
);

`ifdef IFETCH_ALIGN_CHK_EN
  typedef enum logic [1:0] {StReq, StWait, StHold, StFault} state_e;
`else
  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        instr_valid_q, instr_valid_d;
  // Set when a redirect lands while a request is in flight; the matching response is dropped.
  logic        squash_q, squash_d;
  logic [31:0] fetch_addr;

`ifdef IFETCH_ALIGN_CHK_EN
  logic fetch_fault_q, fetch_fault_d;
  logic misaligned;

  assign fetch_addr = fetch_pc_q;
  assign misaligned = |fetch_pc_q[1:0];
`else
  // Without the alignment check, memory only ever sees word addresses.
  assign fetch_addr = {fetch_pc_q[31:2], 2'b00};
`endif

  // -------------------------------------------------------------------------------------------
  // Next-state and request logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    squash_d      = squash_q;
    imem_req      = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
    fetch_fault_d = fetch_fault_q;
`endif

    case (state_q)
      StReq: begin
        if (pc_wr_en) begin
          // A ready seen alongside a redirect is not an acceptance: no request was driven.
          fetch_pc_d = pc_next;
`ifdef IFETCH_ALIGN_CHK_EN
        end else if (misaligned) begin
          state_d       = StFault;
          fetch_fault_d = 1'b1;
`endif
        end else begin
          // Held low during reset so the first request follows reset release.
          imem_req = ~reset;
          if (imem_ready) begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        if (pc_wr_en) begin
          fetch_pc_d = pc_next;
          squash_d   = 1'b1;
        end
        if (imem_rvalid) begin
          if (squash_q || pc_wr_en) begin
            state_d  = StReq;
            squash_d = 1'b0;
          end else begin
            instr_d       = imem_rdata;
            pc_d          = fetch_addr;
            instr_valid_d = 1'b1;
            state_d       = StHold;
          end
        end
      end

      StHold: begin
        // Redirect wins over the sequential advance, even if the word is consumed this cycle.
        if (pc_wr_en) begin
          fetch_pc_d    = pc_next;
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end else if (instr_ready) begin
          fetch_pc_d    = fetch_pc_q + 32'd4;
          instr_valid_d = 1'b0;
          state_d       = StReq;
        end
      end

`ifdef IFETCH_ALIGN_CHK_EN
      StFault: begin
        instr_valid_d = 1'b0;
        if (pc_wr_en) begin
          fetch_pc_d    = pc_next;
          fetch_fault_d = 1'b0;
          state_d       = StReq;
        end
      end
`endif

      default: begin
        state_d = StReq;
      end
    endcase
  end

  // -------------------------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StReq;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= 32'h0;
      pc_q          <= 32'h0;
      instr_valid_q <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      squash_q      <= squash_d;
    end
  end

`ifdef IFETCH_ALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_fault_q <= 1'b0;
    end else begin
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign fetch_fault = fetch_fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  assign imem_addr   = fetch_addr;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a randomized run that is
// scored against a transaction-level model of the fetch stream.

module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_wr_en;
  logic [31:0] pc_next;
  logic        fetch_fault;

  int n_pass;
  int n_total;

  instr_fetch #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .pc         (pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_wr_en   (pc_wr_en),
    .pc_next    (pc_next),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of the bench's instruction memory.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_0013;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    pc_wr_en    = 1'b0;
    pc_next     = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Reset wins over redirect and memory responses; outputs are cleared while reset is high.
  task automatic test_reset();
    reset       = 1'b1;
    pc_wr_en    = 1'b1;
    pc_next     = 32'h0000_0abc;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hffff_ffff;
    imem_ready  = 1'b1;
    step();
    step();
    idle_inputs();
    #1;
    n_total++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid);
    else n_pass++;
    n_total++;
    if (instr !== 32'h0 || pc !== 32'h0)
      $display("FAIL reset_instr_pc: got %h/%h want 0/0", instr, pc);
    else n_pass++;
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
    else n_pass++;
    n_total++;
    if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fetch_fault);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL reset_first_req: got %b@%h want 1@%h", imem_req, imem_addr, RESET_PC);
    else n_pass++;
  endtask

  // Fastest path: accept, respond next cycle, instr_valid two cycles after reset release.
  task automatic test_first_fetch();
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0041_0093;
    #1;
    n_total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL first_wait: req=%b valid=%b want 0/0", imem_req, instr_valid);
    else n_pass++;
    step();
    imem_rvalid = 1'b0;
    #1;
    n_total++;
    if (instr_valid !== 1'b1 || instr !== 32'h0041_0093 || pc !== 32'h0)
      $display("FAIL first_instr: got v=%b %h@%h want 1 00410093@0", instr_valid, instr, pc);
    else n_pass++;
  endtask

  // Back-pressure in HOLD, ignored stray responses, then sequential advance.
  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      #1;
      n_total++;
      if (instr_valid !== 1'b1 || instr !== 32'h0041_0093 || pc !== 32'h0 || imem_req !== 1'b0)
        $display("FAIL hold_stable: v=%b %h@%h req=%b", instr_valid, instr, pc, imem_req);
      else n_pass++;
      step();
    end
    imem_rvalid = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0)
      $display("FAIL hold_advance: req=%b addr=%h v=%b want 1/4/0", imem_req, imem_addr,
               instr_valid);
    else n_pass++;
  endtask

  // Redirects during WAIT, with the response in the same cycle and one cycle later.
  task automatic test_redirect_wait();
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    pc_wr_en    = 1'b1;
    pc_next     = 32'h0000_0100;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hdead_beef;
    #1;
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL redir_req_low: got %b want 0", imem_req);
    else n_pass++;
    step();
    pc_wr_en    = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    n_total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL redir_same: v=%b req=%b addr=%h want 0/1/100", instr_valid, imem_req,
               imem_addr);
    else n_pass++;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    pc_wr_en   = 1'b1;
    pc_next    = 32'h0000_0200;
    step();
    pc_wr_en    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    #1;
    n_total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL redir_late_wait: v=%b req=%b want 0/0", instr_valid, imem_req);
    else n_pass++;
    step();
    imem_rvalid = 1'b0;
    #1;
    n_total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL redir_late: v=%b req=%b addr=%h want 0/1/200", instr_valid, imem_req,
               imem_addr);
    else n_pass++;
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word_at(32'h200);
    step();
    imem_rvalid = 1'b0;
    #1;
    n_total++;
    if (instr_valid !== 1'b1 || pc !== 32'h200 || instr !== word_at(32'h200))
      $display("FAIL redir_refetch: v=%b %h@%h want 1 %h@200", instr_valid, instr, pc,
               word_at(32'h200));
    else n_pass++;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  // Sequential advance wraps at the top of the address space.
  task automatic test_wrap();
    pc_wr_en = 1'b1;
    pc_next  = 32'hffff_fffc;
    step();
    pc_wr_en = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hffff_fffc)
      $display("FAIL wrap_top: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
    else n_pass++;
    imem_ready = 1'b1;
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word_at(32'hffff_fffc);
    step();
    imem_rvalid = 1'b0;
    instr_ready = 1'b1;
    #1;
    n_total++;
    if (instr_valid !== 1'b1 || pc !== 32'hffff_fffc)
      $display("FAIL wrap_hold: v=%b pc=%h want 1/fffffffc", instr_valid, pc);
    else n_pass++;
    step();
    instr_ready = 1'b0;
    #1;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL wrap_zero: req=%b addr=%h want 1/0", imem_req, imem_addr);
    else n_pass++;
  endtask

  // Reset while a request is outstanding abandons it.
  task automatic test_reset_in_wait();
    pc_wr_en = 1'b1;
    pc_next  = 32'h0000_0300;
    step();
    pc_wr_en   = 1'b0;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL reset_wait: v=%b req=%b addr=%h want 0/1/%h", instr_valid, imem_req,
               imem_addr, RESET_PC);
    else n_pass++;
  endtask

  // Misaligned redirect target: fault parking with the check, word alignment without it.
  task automatic test_align();
    pc_wr_en = 1'b1;
    pc_next  = 32'h0000_0102;
    step();
    pc_wr_en = 1'b0;
    #1;
`ifdef IFETCH_ALIGN_CHK_EN
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL align_no_req: got %b want 0", imem_req);
    else n_pass++;
    step();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0)
        $display("FAIL align_fault: fault=%b req=%b v=%b want 1/0/0", fetch_fault, imem_req,
                 instr_valid);
      else n_pass++;
      step();
    end
    imem_ready = 1'b0;
    pc_wr_en   = 1'b1;
    pc_next    = 32'h0000_0200;
    step();
    pc_wr_en = 1'b0;
    #1;
    n_total++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      $display("FAIL align_clear: fault=%b req=%b addr=%h want 0/1/200", fetch_fault, imem_req,
               imem_addr);
    else n_pass++;
`else
    n_total++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL align_mask: fault=%b req=%b addr=%h want 0/1/100", fetch_fault, imem_req,
               imem_addr);
    else n_pass++;
`endif
  endtask

  // Randomized traffic scored against a model of the fetch stream: which address should be
  // requested next, which responses survive, and what the held instruction must be.
  logic        m_out;
  logic [31:0] m_addr;
  int          m_delay;
  logic        m_squash;
  logic [31:0] m_exp_pc;
  logic        m_expect;
  logic [31:0] m_epc;
  logic        m_hold;
  logic [31:0] m_hpc;

  task automatic test_random();
    int unsigned tmp;
    do_reset();
    m_out    = 1'b0;
    m_addr   = 32'h0;
    m_delay  = 0;
    m_squash = 1'b0;
    m_exp_pc = RESET_PC;
    m_expect = 1'b0;
    m_epc    = 32'h0;
    m_hold   = 1'b0;
    m_hpc    = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      imem_ready  = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      pc_wr_en    = ($urandom_range(0, 11) == 0);
      tmp         = $urandom_range(0, 255);
      pc_next     = (tmp < 8) ? (32'hffff_ffe0 + (tmp << 2)) : (tmp << 2);
      if (m_out && m_delay == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(m_addr);
      end else if (!m_out && $urandom_range(0, 3) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      #1;

      if (pc_wr_en) begin
        n_total++;
        if (imem_req !== 1'b0) $display("FAIL rnd_req_on_redirect: cyc %0d req=%b", c, imem_req);
        else n_pass++;
      end
      n_total++;
      if (m_out && imem_req !== 1'b0)
        $display("FAIL rnd_outstanding: cyc %0d req=%b with request in flight", c, imem_req);
      else n_pass++;
      if (imem_req === 1'b1 && imem_ready) begin
        n_total++;
        if (imem_addr !== m_exp_pc)
          $display("FAIL rnd_addr: cyc %0d got %h want %h", c, imem_addr, m_exp_pc);
        else n_pass++;
      end
      n_total++;
      if (fetch_fault !== 1'b0) $display("FAIL rnd_fault: cyc %0d got %b want 0", c, fetch_fault);
      else n_pass++;

      n_total++;
      if (m_expect) begin
        if (instr_valid !== 1'b1 || pc !== m_epc || instr !== word_at(m_epc))
          $display("FAIL rnd_deliver: cyc %0d v=%b %h@%h want 1 %h@%h", c, instr_valid, instr,
                   pc, word_at(m_epc), m_epc);
        else n_pass++;
        m_hold   = 1'b1;
        m_hpc    = m_epc;
        m_expect = 1'b0;
      end else if (m_hold) begin
        if (instr_valid !== 1'b1 || pc !== m_hpc || instr !== word_at(m_hpc))
          $display("FAIL rnd_hold: cyc %0d v=%b %h@%h want 1 %h@%h", c, instr_valid, instr, pc,
                   word_at(m_hpc), m_hpc);
        else n_pass++;
      end else begin
        if (instr_valid !== 1'b0) $display("FAIL rnd_spurious: cyc %0d v=%b want 0", c, instr_valid);
        else n_pass++;
      end

      if (imem_rvalid && m_out) begin
        m_out = 1'b0;
        if (!m_squash && !pc_wr_en) begin
          m_expect = 1'b1;
          m_epc    = m_addr;
        end
      end else if (m_out) begin
        m_delay--;
      end
      if (pc_wr_en) begin
        if (m_out) m_squash = 1'b1;
        m_exp_pc = pc_next;
        m_hold   = 1'b0;
      end else if (m_hold && instr_ready) begin
        m_exp_pc = m_hpc + 32'd4;
        m_hold   = 1'b0;
      end
      if (imem_req === 1'b1 && imem_ready) begin
        m_out    = 1'b1;
        m_addr   = imem_addr;
        m_delay  = int'($urandom_range(0, 2));
        m_squash = 1'b0;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect_wait();
    test_wrap();
    test_reset_in_wait();
    test_align();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
